microseq_ctrl: RTL and testbench

- Second-generation CPU control sequencer. Merges the step counter and the instruction decoder into one clocked block.
- Adds a latched flags register, variable-length instructions (early end-of-instruction), a stall enable, and a sticky halt state.
- Sits between the instruction register, which supplies the opcode, and the datapath, which receives the control word.
- Drives the same 16-bit control word encoding as the current CPU.

---
 rtl/microseq_ctrl.sv | 138 +++++++++++++
 tb/tb_microseq_ctrl.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/microseq_ctrl.sv
// microseq_ctrl: CPU control sequencer. It combines the step counter and the
// instruction decoder, and adds a latched flags register, an optional early
// end of instruction, a step enable and a sticky halt state.
// The 16-bit control word is {hlt, marwa, ramwa, ramoa, inregoa, inregwa, awa,
// aoa, sumout, sub, bwa, outregwa, pcinc, pcoe, pcjmp, flagsin}.
module microseq_ctrl #(
   parameter int STEP_W    = 3,
   parameter int MAX_STEPS = 5,
   parameter int EARLY_END = 1,
   parameter int OP_W      = 4
) (
   input  logic              clk,
   input  logic              clr_n,
   input  logic              en,
   input  logic [OP_W-1:0]   opcode,
   input  logic              cf_in,
   input  logic              zf_in,
   output logic [15:0]       ctrl,
   output logic [STEP_W-1:0] step,
   output logic [1:0]        flags_q,
   output logic              halted
);

   typedef enum logic {
      S_RUN  = 1'b0,
      S_HALT = 1'b1
   } state_t;

   state_t            r_state;
   state_t            w_state_next;
   logic [STEP_W-1:0] r_step;
   logic [STEP_W-1:0] w_step_next;
   logic [1:0]        r_flags;
   logic [1:0]        w_flags_next;
   logic              w_op_high;
   logic [3:0]        w_op;
   logic [STEP_W-1:0] w_last;
   logic [15:0]       w_ctrl;
   logic              w_is_hlt;

   // Any set opcode bit above bit 3 turns the instruction into a NOP.
   generate
      if (OP_W > 4) begin : g_wide_op
         assign w_op_high = |opcode[OP_W-1:4];
      end else begin : g_narrow_op
         assign w_op_high = 1'b0;
      end
   endgenerate

   assign w_op = w_op_high ? 4'h0 : opcode[3:0];

   // Last step of the current instruction: per-opcode length or fixed length.
   always_comb begin
      w_last = STEP_W'(MAX_STEPS - 1);
      if (EARLY_END != 0) begin
         case (w_op)
            4'h1, 4'h4: w_last = STEP_W'(3);
            4'h2, 4'h3: w_last = STEP_W'(4);
            default:    w_last = STEP_W'(2);
         endcase
      end
   end

   // Control word decode from step, opcode, latched flags and halt state.
   always_comb begin
      w_ctrl = 16'h0000;
      if (r_state == S_HALT) begin
         w_ctrl = 16'h8000;
      end else if (r_step == STEP_W'(0)) begin
         w_ctrl = 16'h4004;
      end else if (r_step == STEP_W'(1)) begin
         w_ctrl = 16'h1408;
      end else if (r_step == STEP_W'(2)) begin
         case (w_op)
            4'h1, 4'h2, 4'h3, 4'h4: w_ctrl = 16'h4800;
            4'h5:    w_ctrl = 16'h0A00;
            4'h6:    w_ctrl = 16'h0802;
            4'h7:    w_ctrl = r_flags[1] ? 16'h0802 : 16'h0000;
            4'h8:    w_ctrl = r_flags[0] ? 16'h0802 : 16'h0000;
            4'hE:    w_ctrl = 16'h0110;
            4'hF:    w_ctrl = 16'h8000;
            default: w_ctrl = 16'h0000;
         endcase
      end else if (r_step == STEP_W'(3)) begin
         case (w_op)
            4'h1:       w_ctrl = 16'h1200;
            4'h2, 4'h3: w_ctrl = 16'h1020;
            4'h4:       w_ctrl = 16'h2100;
            default:    w_ctrl = 16'h0000;
         endcase
      end else if (r_step == STEP_W'(4)) begin
         case (w_op)
            4'h2:    w_ctrl = 16'h0281;
            4'h3:    w_ctrl = 16'h02C1;
            default: w_ctrl = 16'h0000;
         endcase
      end
   end

   // Next state: advance or wrap the step, latch flags, enter sticky halt.
   always_comb begin
      w_state_next = r_state;
      w_step_next  = r_step;
      w_flags_next = r_flags;
      w_is_hlt     = (w_op == 4'hF) && (r_step == STEP_W'(2));
      if (en && (r_state == S_RUN)) begin
         if (w_ctrl[0]) begin
            w_flags_next = {cf_in, zf_in};
         end
         if (w_is_hlt) begin
            w_state_next = S_HALT;
         end else if (r_step == w_last) begin
            w_step_next = '0;
         end else begin
            w_step_next = r_step + STEP_W'(1);
         end
      end
   end

   // State registers; clr_n returns to step 0 fetch from any state.
   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         r_state <= S_RUN;
         r_step  <= '0;
         r_flags <= 2'b00;
      end else begin
         r_state <= w_state_next;
         r_step  <= w_step_next;
         r_flags <= w_flags_next;
      end
   end

   assign ctrl    = w_ctrl;
   assign step    = r_step;
   assign flags_q = r_flags;
   assign halted  = (r_state == S_HALT);

endmodule

// File: tb/tb_microseq_ctrl.sv
// tb_microseq_ctrl: directed tests for microseq_ctrl. u_dut runs with early
// end of instruction; u_fix runs fixed-length with a 6-bit opcode.
module tb_microseq_ctrl;

   logic        clk;
   logic        clr_n, en, cf_in, zf_in;
   logic [3:0]  opcode;
   logic [15:0] ctrl;
   logic [2:0]  step;
   logic [1:0]  flags_q;
   logic        halted;

   logic        clr2_n, en2;
   logic [5:0]  opcode2;
   logic [15:0] ctrl2;
   logic [2:0]  step2;
   logic [1:0]  flags2;
   logic        halted2;

   int total = 0;
   int bad   = 0;

   microseq_ctrl #(.STEP_W(3), .MAX_STEPS(5), .EARLY_END(1), .OP_W(4)) u_dut (
      .clk(clk), .clr_n(clr_n), .en(en), .opcode(opcode), .cf_in(cf_in),
      .zf_in(zf_in), .ctrl(ctrl), .step(step), .flags_q(flags_q), .halted(halted)
   );

   microseq_ctrl #(.STEP_W(3), .MAX_STEPS(5), .EARLY_END(0), .OP_W(6)) u_fix (
      .clk(clk), .clr_n(clr2_n), .en(en2), .opcode(opcode2), .cf_in(1'b1),
      .zf_in(1'b1), .ctrl(ctrl2), .step(step2), .flags_q(flags2), .halted(halted2)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      clr_n = 1'b0;
      @(negedge clk);
      clr_n = 1'b1;
   endtask

   task automatic test_reset();
      clr_n = 1'b0; en = 1'b1; opcode = 4'h2; cf_in = 1'b1; zf_in = 1'b1;
      #1;
      total++;
      if ({ctrl, step, flags_q, halted} !== {16'h4004, 3'd0, 2'b00, 1'b0}) begin
         bad++;
         $display("FAIL reset: got ctrl=%h step=%0d flags=%b halt=%b want 4004/0/00/0",
                  ctrl, step, flags_q, halted);
      end
      $display("test_reset: ctrl=%h step=%0d", ctrl, step);
      @(negedge clk);
      clr_n = 1'b1;
   endtask

   task automatic test_lda();
      logic [15:0] ec [5];
      logic [2:0]  es [5];
      ec = '{16'h4004, 16'h1408, 16'h4800, 16'h1200, 16'h4004};
      es = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd0};
      en = 1'b1; opcode = 4'h1;
      do_reset();
      for (int i = 0; i < 5; i++) begin
         if (i > 0) tick();
         total++;
         if ({ctrl, step} !== {ec[i], es[i]}) begin
            bad++;
            $display("FAIL lda_seq%0d: got ctrl=%h step=%0d want ctrl=%h step=%0d",
                     i, ctrl, step, ec[i], es[i]);
         end
         $display("test_lda: cycle %0d ctrl=%h step=%0d", i, ctrl, step);
      end
   endtask

   task automatic test_add_flags();
      en = 1'b1; opcode = 4'h2; cf_in = 1'b1; zf_in = 1'b0;
      do_reset();
      repeat (4) tick();
      total++;
      if ({ctrl, step} !== {16'h0281, 3'd4}) begin
         bad++;
         $display("FAIL add_s4: got ctrl=%h step=%0d want ctrl=0281 step=4", ctrl, step);
      end
      tick();
      total++;
      if ({flags_q, step} !== {2'b10, 3'd0}) begin
         bad++;
         $display("FAIL add_flags: got flags=%b step=%0d want flags=10 step=0", flags_q, step);
      end
      opcode = 4'h7;
      repeat (2) tick();
      total++;
      if ({ctrl, step} !== {16'h0802, 3'd2}) begin
         bad++;
         $display("FAIL jc_taken: got ctrl=%h step=%0d want ctrl=0802 step=2", ctrl, step);
      end
      tick();
      total++;
      if ({flags_q, step} !== {2'b10, 3'd0}) begin
         bad++;
         $display("FAIL jc_end: got flags=%b step=%0d want flags=10 step=0", flags_q, step);
      end
      opcode = 4'h8;
      repeat (2) tick();
      total++;
      if ({ctrl, step} !== {16'h0000, 3'd2}) begin
         bad++;
         $display("FAIL jz_not_taken: got ctrl=%h step=%0d want ctrl=0000 step=2", ctrl, step);
      end
      tick();
      $display("test_add_flags: flags=%b", flags_q);
   endtask

   task automatic test_sub_jz();
      en = 1'b1; opcode = 4'h3; cf_in = 1'b0; zf_in = 1'b1;
      do_reset();
      repeat (4) tick();
      total++;
      if ({ctrl, step} !== {16'h02C1, 3'd4}) begin
         bad++;
         $display("FAIL sub_s4: got ctrl=%h step=%0d want ctrl=02c1 step=4", ctrl, step);
      end
      tick();
      total++;
      if ({flags_q, step} !== {2'b01, 3'd0}) begin
         bad++;
         $display("FAIL sub_flags: got flags=%b step=%0d want flags=01 step=0", flags_q, step);
      end
      opcode = 4'h8;
      repeat (2) tick();
      total++;
      if ({ctrl, step} !== {16'h0802, 3'd2}) begin
         bad++;
         $display("FAIL jz_taken: got ctrl=%h step=%0d want ctrl=0802 step=2", ctrl, step);
      end
      $display("test_sub_jz: ctrl=%h", ctrl);
   endtask

   task automatic test_fixed_len();
      logic [15:0] ec [6];
      logic [2:0]  es [6];
      logic [5:0]  ops [2];
      ec = '{16'h4004, 16'h1408, 16'h0000, 16'h0000, 16'h0000, 16'h4004};
      es = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd0};
      ops = '{6'h00, 6'h11};
      for (int p = 0; p < 2; p++) begin
         en2 = 1'b1; opcode2 = ops[p]; clr2_n = 1'b0;
         @(negedge clk);
         clr2_n = 1'b1;
         for (int i = 0; i < 6; i++) begin
            if (i > 0) tick();
            total++;
            if ({ctrl2, step2} !== {ec[i], es[i]}) begin
               bad++;
               $display("FAIL fixed_op%h_c%0d: got ctrl=%h step=%0d want ctrl=%h step=%0d",
                        ops[p], i, ctrl2, step2, ec[i], es[i]);
            end
         end
         $display("test_fixed_len: opcode=%h done", ops[p]);
      end
   endtask

   task automatic test_halt();
      en = 1'b1; opcode = 4'hF;
      do_reset();
      repeat (2) tick();
      total++;
      if ({ctrl, step, halted} !== {16'h8000, 3'd2, 1'b0}) begin
         bad++;
         $display("FAIL hlt_s2: got ctrl=%h step=%0d halt=%b want 8000/2/0", ctrl, step, halted);
      end
      tick();
      opcode = 4'h1;
      for (int i = 0; i < 10; i++) begin
         total++;
         if ({ctrl, step, halted} !== {16'h8000, 3'd2, 1'b1}) begin
            bad++;
            $display("FAIL halted_c%0d: got ctrl=%h step=%0d halt=%b want 8000/2/1",
                     i, ctrl, step, halted);
         end
         tick();
      end
      #2;
      clr_n = 1'b0;
      #1;
      total++;
      if ({ctrl, step, halted} !== {16'h4004, 3'd0, 1'b0}) begin
         bad++;
         $display("FAIL halt_clear: got ctrl=%h step=%0d halt=%b want 4004/0/0", ctrl, step, halted);
      end
      @(negedge clk);
      clr_n = 1'b1;
      $display("test_halt: cleared ctrl=%h", ctrl);
   endtask

   task automatic test_en_stall();
      en = 1'b1; opcode = 4'h2; cf_in = 1'b1; zf_in = 1'b1;
      do_reset();
      repeat (4) tick();
      en = 1'b0;
      for (int i = 0; i < 3; i++) begin
         cf_in = ~cf_in;
         tick();
         total++;
         if ({ctrl, step, flags_q} !== {16'h0281, 3'd4, 2'b00}) begin
            bad++;
            $display("FAIL stall_c%0d: got ctrl=%h step=%0d flags=%b want 0281/4/00",
                     i, ctrl, step, flags_q);
         end
      end
      en = 1'b1; cf_in = 1'b1; zf_in = 1'b1;
      tick();
      total++;
      if ({step, flags_q} !== {3'd0, 2'b11}) begin
         bad++;
         $display("FAIL stall_resume: got step=%0d flags=%b want step=0 flags=11", step, flags_q);
      end
      $display("test_en_stall: flags=%b", flags_q);
   endtask

   initial begin
      clr2_n = 1'b0; en2 = 1'b0; opcode2 = 6'h00;
      test_reset();
      test_lda();
      test_add_flags();
      test_sub_jz();
      test_fixed_len();
      test_halt();
      test_en_stall();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
